// File: rtl/pwl_table_loader.sv
// pwl_table_loader
//   Loads a piecewise-linear table from a 32-bit valid/ready word stream.
//   The stream carries K segment endpoints, then K a-coefficients, then K
//   b-coefficients. Endpoints are collected in a shadow copy and published on
//   xend_flat only when the whole table has arrived. Coefficients are written
//   straight into external a/b memories through registered one-cycle strobes.
//
//   Optional build macro: PWL_LOADER_CHECKSUM_EN
//     When defined, one extra word follows the 3K table words. It must equal
//     the XOR of those 3K words, otherwise the table is rejected (err=1).
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   start                single-cycle load request (honoured only when idle)
//   s_valid/s_ready      stream handshake; s_data is the stream word
//   xend_flat            committed endpoints, entry i at [i*N +: N]
//   ena_a/wea_a          a-coefficient memory strobes
//   ena_b/wea_b          b-coefficient memory strobes
//   addr, din            coefficient memory write address / data
//   busy, done           load in progress / one-cycle completion pulse
//   table_valid, err     committed table valid / sticky checksum error
//
// State    | meaning
// IDLE     | waiting for start
// LD_XEND  | receiving K endpoints into the shadow copy
// LD_A     | receiving K a-coefficients
// LD_B     | receiving K b-coefficients
// CHK      | receiving the checksum word (checksum build only)
// COMMIT   | publishing shadow endpoints, one cycle
module pwl_table_loader #(
  parameter int K = 7,
  parameter int N = 31
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [31:0]    s_data,
  output logic [K*N-1:0] xend_flat,
  output logic           ena_a,
  output logic           wea_a,
  output logic           ena_b,
  output logic           wea_b,
  output logic [2:0]     addr,
  output logic [31:0]    din,
  output logic           busy,
  output logic           done,
  output logic           table_valid,
  output logic           err
);

  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LD_XEND,
    LD_A,
    LD_B,
`ifdef PWL_LOADER_CHECKSUM_EN
    CHK,
`endif
    COMMIT
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [K*N-1:0] shadow_q, xend_q;
  logic           ena_a_q, ena_b_q;
  logic [2:0]     addr_q;
  logic [31:0]    din_q;
  logic           done_q, table_valid_q, err_q;
  logic           accept, last, start_acc, chk_fail;

  assign accept    = s_valid && s_ready;
  assign last      = (cnt_q == CW'(K - 1));
  assign start_acc = (state_q == IDLE) && start;

`ifdef PWL_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running XOR of every table word; the CHK word is compared against it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (start_acc) begin
      csum_q <= '0;
    end else if (accept && (state_q == LD_XEND || state_q == LD_A || state_q == LD_B)) begin
      csum_q <= csum_q ^ s_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_ready  = 1'b0;
    chk_fail = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LD_XEND;
      end
      LD_XEND, LD_A, LD_B: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (last) begin
            cnt_d = '0;
            if (state_q == LD_XEND)   state_d = LD_A;
            else if (state_q == LD_A) state_d = LD_B;
`ifdef PWL_LOADER_CHECKSUM_EN
            else                      state_d = CHK;
`else
            else                      state_d = COMMIT;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef PWL_LOADER_CHECKSUM_EN
      CHK: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_data == csum_q) begin
            state_d = COMMIT;
          end else begin
            state_d  = IDLE;
            chk_fail = 1'b1;
          end
        end
      end
`endif
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes, addr and din are rebuilt every cycle so they read 0 between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q      <= '0;
      xend_q        <= '0;
      ena_a_q       <= 1'b0;
      ena_b_q       <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      done_q        <= 1'b0;
      table_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ena_a_q <= 1'b0;
      ena_b_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      if (start_acc) begin
        table_valid_q <= 1'b0;
        err_q         <= 1'b0;
      end
      for (int i = 0; i < K; i++) begin
        if (accept && state_q == LD_XEND && cnt_q == CW'(i))
          shadow_q[i*N +: N] <= s_data[N-1:0];
      end
      if (accept && (state_q == LD_A || state_q == LD_B)) begin
        ena_a_q <= (state_q == LD_A);
        ena_b_q <= (state_q == LD_B);
        addr_q  <= 3'(cnt_q);
        din_q   <= s_data;
      end
      if (state_q == COMMIT) begin
        xend_q        <= shadow_q;
        table_valid_q <= 1'b1;
        done_q        <= 1'b1;
      end
      if (chk_fail) begin
        err_q  <= 1'b1;
        done_q <= 1'b1;
      end
    end
  end

  assign xend_flat   = xend_q;
  assign ena_a       = ena_a_q;
  assign wea_a       = ena_a_q;
  assign ena_b       = ena_b_q;
  assign wea_b       = ena_b_q;
  assign addr        = addr_q;
  assign din         = din_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign table_valid = table_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pwl_table_loader.sv
module tb_pwl_table_loader;
  localparam int K = 7;
  localparam int N = 31;

  logic           clk, rst, start, s_valid, s_ready;
  logic [31:0]    s_data;
  logic [K*N-1:0] xend_flat;
  logic           ena_a, wea_a, ena_b, wea_b;
  logic [2:0]     addr;
  logic [31:0]    din;
  logic           busy, done, table_valid, err;

  int tests = 0;
  int fails = 0;

  pwl_table_loader #(.K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .xend_flat(xend_flat), .ena_a(ena_a), .wea_a(wea_a),
    .ena_b(ena_b), .wea_b(wea_b), .addr(addr), .din(din), .busy(busy),
    .done(done), .table_valid(table_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge.
  int          na, nb, ndone, nbad, cyc, done_cyc, last_b_cyc;
  logic [2:0]  a_addr [8];
  logic [31:0] a_din  [8];
  logic [2:0]  b_addr [8];
  logic [31:0] b_din  [8];

  initial cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (ena_a === 1'b1) begin
      if (na < 8) begin a_addr[na] = addr; a_din[na] = din; end
      na++;
    end
    if (ena_b === 1'b1) begin
      if (nb < 8) begin b_addr[nb] = addr; b_din[nb] = din; end
      nb++;
      last_b_cyc = cyc;
    end
    if (done === 1'b1) begin ndone++; done_cyc = cyc; end
    if (ena_a !== wea_a || ena_b !== wea_b || (ena_a && ena_b) ||
        (!ena_a && !ena_b && (addr !== 3'd0 || din !== 32'd0)))
      nbad++;
  end

  task automatic clear_log();
    na = 0; nb = 0; ndone = 0; nbad = 0; done_cyc = 0; last_b_cyc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one word and waits (bounded) for its acceptance; gap = idle cycles after.
  task automatic send_word(input logic [31:0] w, input int gap);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (1) begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      t++;
      if (t > 50) begin
        tests++; fails++;
        $display("FAIL send_word timeout: word %h never accepted", w);
        break;
      end
    end
    @(posedge clk); #1;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_words(input int first, input int count, input int gap, input logic [31:0] offs);
    for (int i = 0; i < count; i++) send_word(offs + 32'(first + i), gap);
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (ndone == 0 && t < 40) begin @(negedge clk); t++; end
    if (ndone == 0) begin
      tests++; fails++;
      $display("FAIL %s done timeout: got none, expected one pulse", nm);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({s_ready, ena_a, wea_a, ena_b, wea_b, addr, din, busy, done, table_valid, err} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got %b/%h/%h/%b, expected all zero", {s_ready, ena_a, wea_a, ena_b, wea_b},
               addr, din, {busy, done, table_valid, err});
    end
    tests++;
    if (xend_flat !== '0) begin
      fails++; $display("FAIL reset xend: got %h expected 0", xend_flat);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    clear_log();
    pulse_start();
    tests++;
    if (busy !== 1'b1 || table_valid !== 1'b0) begin
      fails++; $display("FAIL b2b start status: busy=%b tv=%b expected busy=1 tv=0", busy, table_valid);
    end
    send_words(1, 7, 0, 0);
    tests++;
    if (xend_flat !== '0) begin
      fails++; $display("FAIL b2b xend before commit: got %h expected 0", xend_flat);
    end
    send_words(8, 14, 0, 0);
    s_valid = 1'b0;
    wait_done("b2b");
    for (int i = 0; i < K; i++) begin
      tests++;
      if (xend_flat[i*N +: N] !== 31'(i + 1) || a_addr[i] !== 3'(i) || a_din[i] !== 32'(8 + i) ||
          b_addr[i] !== 3'(i) || b_din[i] !== 32'(15 + i)) begin
        fails++;
        $display("FAIL b2b entry %0d: xend=%0d a=%0d/%0d b=%0d/%0d expected %0d a=%0d/%0d b=%0d/%0d",
                 i, xend_flat[i*N +: N], a_addr[i], a_din[i], b_addr[i], b_din[i], i + 1, i, 8 + i, i, 15 + i);
      end
    end
    tests++;
    if (na !== 7 || nb !== 7 || ndone !== 1 || nbad !== 0 || done_cyc < last_b_cyc) begin
      fails++;
      $display("FAIL b2b counts: a=%0d b=%0d done=%0d bad=%0d done_cyc=%0d last_b=%0d expected 7 7 1 0 done>=last_b",
               na, nb, ndone, nbad, done_cyc, last_b_cyc);
    end
    tests++;
    if (table_valid !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL b2b final status: tv=%b busy=%b err=%b expected 1 0 0", table_valid, busy, err);
    end
  endtask

  task automatic test_gaps();
    clear_log();
    pulse_start();
    tests++;
    if (table_valid !== 1'b0) begin
      fails++; $display("FAIL gaps tv clear on start: got %b expected 0", table_valid);
    end
    send_words(1, 21, 1, 0);
    wait_done("gaps");
    for (int i = 0; i < K; i++) begin
      tests++;
      if (xend_flat[i*N +: N] !== 31'(i + 1) || a_addr[i] !== 3'(i) || a_din[i] !== 32'(8 + i) ||
          b_addr[i] !== 3'(i) || b_din[i] !== 32'(15 + i)) begin
        fails++;
        $display("FAIL gaps entry %0d: xend=%0d a=%0d/%0d b=%0d/%0d expected %0d a=%0d/%0d b=%0d/%0d",
                 i, xend_flat[i*N +: N], a_addr[i], a_din[i], b_addr[i], b_din[i], i + 1, i, 8 + i, i, 15 + i);
      end
    end
    tests++;
    if (na !== 7 || nb !== 7 || ndone !== 1 || nbad !== 0 || table_valid !== 1'b1) begin
      fails++;
      $display("FAIL gaps counts: a=%0d b=%0d done=%0d bad=%0d tv=%b expected 7 7 1 0 1", na, nb, ndone, nbad, table_valid);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    pulse_start();
    send_words(1, 10, 0, 0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({s_ready, ena_a, wea_a, ena_b, wea_b, addr, din, busy, done, table_valid, err} !== '0) begin
      fails++;
      $display("FAIL midrst outputs: got %b/%h/%h/%b, expected all zero", {s_ready, ena_a, wea_a, ena_b, wea_b},
               addr, din, {busy, done, table_valid, err});
    end
    tests++;
    if (xend_flat !== '0) begin
      fails++; $display("FAIL midrst xend: got %h expected 0", xend_flat);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    pulse_start();
    send_words(1, 21, 0, 0);
    s_valid = 1'b0;
    wait_done("midrst");
    tests++;
    if (na !== 7 || nb !== 7 || ndone !== 1 || nbad !== 0 || table_valid !== 1'b1 ||
        xend_flat[6*N +: N] !== 31'd7 || b_din[6] !== 32'd21) begin
      fails++;
      $display("FAIL midrst reload: a=%0d b=%0d done=%0d bad=%0d tv=%b x6=%0d b6=%0d expected 7 7 1 0 1 7 21",
               na, nb, ndone, nbad, table_valid, xend_flat[6*N +: N], b_din[6]);
    end
  endtask

  task automatic test_start_ignored();
    clear_log();
    pulse_start();
    send_words(1, 9, 0, 0);
    s_valid = 1'b0;
    pulse_start();
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL ignstart busy: got %b expected 1", busy);
    end
    send_words(10, 12, 0, 0);
    s_valid = 1'b0;
    wait_done("ignstart");
    for (int i = 0; i < K; i++) begin
      tests++;
      if (a_addr[i] !== 3'(i) || a_din[i] !== 32'(8 + i) || b_addr[i] !== 3'(i) || b_din[i] !== 32'(15 + i)) begin
        fails++;
        $display("FAIL ignstart write %0d: a=%0d/%0d b=%0d/%0d expected a=%0d/%0d b=%0d/%0d",
                 i, a_addr[i], a_din[i], b_addr[i], b_din[i], i, 8 + i, i, 15 + i);
      end
    end
    tests++;
    if (na !== 7 || nb !== 7 || ndone !== 1 || table_valid !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL ignstart counts: a=%0d b=%0d done=%0d tv=%b err=%b expected 7 7 1 1 0", na, nb, ndone, table_valid, err);
    end
  endtask

`ifdef PWL_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    // XOR of the words 1..21 is 0x00000001.
    clear_log();
    pulse_start();
    send_words(1, 21, 0, 0);
    send_word(32'h0000_0001, 0);
    s_valid = 1'b0;
    wait_done("csum_ok");
    tests++;
    if (table_valid !== 1'b1 || err !== 1'b0 || ndone !== 1 || xend_flat[0 +: N] !== 31'd1) begin
      fails++;
      $display("FAIL csum_ok: tv=%b err=%b done=%0d x0=%0d expected 1 0 1 1", table_valid, err, ndone, xend_flat[0 +: N]);
    end
    // Words 0x101..0x115 have an odd count of bit-8 ones, so 0 cannot match.
    clear_log();
    pulse_start();
    send_words(1, 21, 0, 32'h100);
    send_word(32'h0000_0000, 0);
    s_valid = 1'b0;
    wait_done("csum_bad");
    tests++;
    if (table_valid !== 1'b0 || err !== 1'b1 || ndone !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL csum_bad status: tv=%b err=%b done=%0d busy=%b expected 0 1 1 0", table_valid, err, ndone, busy);
    end
    tests++;
    if (xend_flat[0 +: N] !== 31'd1 || xend_flat[6*N +: N] !== 31'd7) begin
      fails++;
      $display("FAIL csum_bad xend kept: x0=%0d x6=%0d expected 1 7", xend_flat[0 +: N], xend_flat[6*N +: N]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_reset_mid_load();
    test_start_ignored();
`ifdef PWL_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
